// File: rtl/core_pkg.sv
// Shared core-wide widths and types for the integer register file and its users.
package core_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 2 ** REG_ADDR_W;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xlen_t;

endpackage : core_pkg

// File: rtl/reg_file_scoreboard_decoder.sv
// Binary-to-one-hot decoder; turns a register address into a per-register select vector.
module decoder #(
  parameter int INPUT_WIDTH  = 5,
  parameter int OUTPUT_WIDTH = 2 ** INPUT_WIDTH
) (
  input  logic [INPUT_WIDTH-1:0]  in_i,
  output logic [OUTPUT_WIDTH-1:0] out_o
);

  assign out_o = OUTPUT_WIDTH'(1) << in_i;

endmodule : decoder

// File: rtl/reg_file_scoreboard.sv
// Integer register file with writeback bypass and a per-register busy scoreboard
// used by issue logic to detect RAW (rsN_busy) and WAW (issue_conflict) hazards.
module reg_file_scoreboard #(
  parameter int XLEN       = core_pkg::XLEN,
  parameter int ADDR_WIDTH = core_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic [XLEN-1:0]       rs1_data,
  output logic [XLEN-1:0]       rs2_data,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  output logic                  issue_conflict,
  input  logic                  wb_valid,
  input  logic [ADDR_WIDTH-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_data
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  // x0 is hardwired to zero, so bit 0 of every per-register vector is masked off.
  localparam logic [NUM_REGS-1:0] NOT_X0 = {{(NUM_REGS-1){1'b1}}, 1'b0};

  logic [XLEN-1:0]     regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [NUM_REGS-1:0] wb_onehot, we_vec, set_vec;
  logic                rs1_wb_hit, rs2_wb_hit, issue_wb_hit;

  decoder #(
    .INPUT_WIDTH (ADDR_WIDTH)
  ) u_wb_decoder (
    .in_i  (wb_rd),
    .out_o (wb_onehot)
  );

  assign we_vec = wb_onehot & {NUM_REGS{wb_valid}} & NOT_X0;

  assign rs1_wb_hit   = wb_valid && (wb_rd == rs1_addr);
  assign rs2_wb_hit   = wb_valid && (wb_rd == rs2_addr);
  assign issue_wb_hit = wb_valid && (wb_rd == issue_rd);

  // NOTE: combinational blocks assign a default first so every path drives the output (no latch).
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (rs1_addr != '0) rs1_data = rs1_wb_hit ? wb_data : regs_q[rs1_addr];
    if (rs2_addr != '0) rs2_data = rs2_wb_hit ? wb_data : regs_q[rs2_addr];
  end

  assign rs1_busy = (rs1_addr != '0) && busy_q[rs1_addr] && !rs1_wb_hit;
  assign rs2_busy = (rs2_addr != '0) && busy_q[rs2_addr] && !rs2_wb_hit;

  // A writeback landing on the same register this cycle frees the slot for the new issue.
  assign issue_conflict = issue_valid && (issue_rd != '0) && busy_q[issue_rd] && !issue_wb_hit;

  assign set_vec = (issue_valid && !issue_conflict)
                 ? ((NUM_REGS'(1) << issue_rd) & NOT_X0)
                 : '0;

  // Set is applied after clear so a same-cycle issue and writeback leaves the bit pending.
  assign busy_d = (busy_q & ~we_vec) | set_vec;

  // NOTE: the register array is reset on purpose: software relies on every register reading 0 after reset.
  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      busy_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (we_vec[i]) regs_q[i] <= wb_data;
      end
      busy_q <= busy_d;
    end
  end

endmodule : reg_file_scoreboard
